// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word ready/valid bundle for uart_rx_param
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with one-entry output buffer
// Optional parity check compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 434,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            busy,
  uart_rx_param_if.master m_if
);
  localparam int HALF = CLK_PER_BIT / 2;
  localparam int CW   = $clog2(CLK_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [CW-1:0]        r_clk_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_pend;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_half_tick;
  logic                 w_done;
  logic                 w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!w_rx_s) w_next = S_START;
      S_START:  if (w_half_tick) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick && (r_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) w_next = S_STOP;
`endif
      S_STOP:   if (w_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tick      = (r_clk_cnt == CNT_LAST);
    w_half_tick = (r_clk_cnt == CNT_HALF);
    w_done      = (r_state == S_STOP) && w_tick && (r_stop_idx == STOP_LAST);
    w_busy      = (r_state != S_IDLE);
  end

  // Counter restarts on every state change; in multi-bit states it wraps at mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt   <= '0;
      r_idx       <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_ferr_pend <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == S_IDLE) || w_tick) r_clk_cnt <= '0;
      else                                                      r_clk_cnt <= r_clk_cnt + 1'b1;

      if (r_state == S_START && w_next == S_DATA) begin
        r_idx       <= '0;
        r_ferr_pend <= 1'b0;
      end
      if (r_state == S_DATA && w_tick) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + 1'b1;
      end
      if (r_state != S_STOP)                r_stop_idx <= 1'b0;
      else if (w_tick) begin
        r_stop_idx <= ~r_stop_idx;
        if (!w_rx_s) r_ferr_pend <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic r_perr_pend;
  logic r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_tick) r_perr_pend <= (^r_shift) ^ w_rx_s ^ ODD;
      if (w_done && (!r_valid || m_if.rx_ready)) r_perr <= r_perr_pend;
    end
  end
  assign m_if.parity_err = r_perr;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
  assign m_if.parity_err     = 1'b0;
`endif

  // A completed word only replaces the held one if the consumer takes it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || m_if.rx_ready) begin
          r_data  <= r_shift;
          r_ferr  <= r_ferr_pend | ~w_rx_s;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && m_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_if.rx_data   = r_data;
  assign m_if.rx_valid  = r_valid;
  assign m_if.frame_err = r_ferr;
  assign m_if.overrun   = r_overrun;
  assign busy           = w_busy;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
  localparam int CPB = 16;
  localparam int DB  = 7;
  localparam int SB  = 2;
  localparam int PB  = 1;
`else
  localparam int CPB = 434;
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int PB  = 0;
`endif
  localparam int ODD  = 0;
  localparam int HALF = CPB / 2;
  localparam int NF   = 1 + DB + PB + SB;
  localparam int LAT  = 2 + HALF + (NF - 1) * CPB + 1;
  localparam int GL   = HALF / 2;
  localparam logic [8:0] MASK = 9'((1 << DB) - 1);

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];

  int   n_words = 0;
  int   rise_cyc = 0;
  int   run_len = 0;
  int   last_len = 0;
  int   n_ovr = 0;
  int   ovr_cyc = 0;
  logic prev_v = 1'b0;

  uart_rx_param_if #(.DATA_BITS(DB)) u_if ();

  uart_rx_param #(
    .CLK_PER_BIT (CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (ODD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .busy  (busy),
    .m_if  (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 90000) begin
      $display("FAIL watchdog cycles=%0d limit=90000", cyc);
      $fatal(1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (u_if.rx_valid && !prev_v) begin
      rise_cyc = cyc;
      n_words++;
    end
    if (u_if.rx_valid) run_len++;
    else begin
      if (prev_v) last_len = run_len;
      run_len = 0;
    end
    prev_v = u_if.rx_valid;
    if (u_if.overrun) begin
      n_ovr++;
      ovr_cyc = cyc;
    end
    if (u_if.rx_valid && u_if.rx_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word_data", 32'(u_if.rx_data), 32'(e.data));
        check("word_ferr", 32'(u_if.frame_err), 32'(e.ferr));
        check("word_perr", 32'(u_if.parity_err), 32'(e.perr));
        check("word_cycle", 32'(rise_cyc), 32'(e.cyc));
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input bit stop_low, input bit par_flip,
                            input bit push, output int k);
    logic [8:0] dm;
    exp_t       e;
`ifdef UART_RX_PARITY_EN
    logic       pbit;
`endif
    dm = d & MASK;
    @(negedge clk);
    rx = 1'b0;
    k  = cyc;
    if (push) begin
      e.data = dm;
      e.ferr = stop_low;
      e.perr = (PB == 1) ? par_flip : 1'b0;
      e.cyc  = k + LAT;
      sb.push_back(e);
    end
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < DB; i++) drive_bit(dm[i]);
`ifdef UART_RX_PARITY_EN
    pbit = (^dm) ^ (ODD != 0) ^ par_flip;
    drive_bit(pbit);
`endif
    for (int i = 0; i < SB; i++) drive_bit(!stop_low);
  endtask

  initial begin
    int k;
    int k2;
    int nw;
    int novr;
    rx = 1'b1;
    rst_n = 1'b0;
    u_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(u_if.rx_valid), 32'd0);
    check("rst_data", 32'(u_if.rx_data), 32'd0);
    check("rst_ferr", 32'(u_if.frame_err), 32'd0);
    check("rst_perr", 32'(u_if.parity_err), 32'd0);
    check("rst_ovr", 32'(u_if.overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    u_if.rx_ready = 1'b1;
    idle(10);

    send_frame(9'h0A5, 1'b0, 1'b0, 1'b1, k);
    idle(2 * CPB);
    check("valid_pulse_len", 32'(last_len), 32'd1);

    nw = n_words;
    @(negedge clk);
    rx = 1'b0;
    k  = cyc;
    repeat (GL - 1) @(negedge clk);
    rx = 1'b1;
    while (cyc < k + 2 + HALF) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    idle(2 * CPB);
    check("glitch_no_word", 32'(n_words), 32'(nw));
    send_frame(9'h03C, 1'b0, 1'b0, 1'b1, k);
    idle(2 * CPB);

    send_frame(9'h055, 1'b1, 1'b0, 1'b1, k);
    idle(2 * CPB);
    send_frame(9'h00F, 1'b0, 1'b0, 1'b1, k);
    idle(2 * CPB);

    u_if.rx_ready = 1'b0;
    novr = n_ovr;
    send_frame(9'h011, 1'b0, 1'b0, 1'b1, k);
    send_frame(9'h022, 1'b0, 1'b0, 1'b0, k2);
    idle(4);
    check("ovr_count", 32'(n_ovr), 32'(novr + 1));
    check("ovr_cycle", 32'(ovr_cyc), 32'(k2 + LAT));
    check("held_valid", 32'(u_if.rx_valid), 32'd1);
    check("held_data", 32'(u_if.rx_data), 32'(9'h011 & MASK));
    check("held_ferr", 32'(u_if.frame_err), 32'd0);
    @(negedge clk);
    u_if.rx_ready = 1'b1;
    idle(2 * CPB);
    check("held_drained", 32'(sb.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(9'h041, 1'b0, 1'b0, 1'b1, k);
    idle(2 * CPB);
    send_frame(9'h041, 1'b0, 1'b1, 1'b1, k);
    idle(2 * CPB);
`endif

    u_if.rx_ready = 1'b0;
    send_frame(9'h05A, 1'b0, 1'b0, 1'b0, k);
    idle(CPB);
    check("pre_rst_valid", 32'(u_if.rx_valid), 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(u_if.rx_valid), 32'd0);
    check("mid_rst_data", 32'(u_if.rx_data), 32'd0);
    check("mid_rst_ferr", 32'(u_if.frame_err), 32'd0);
    check("mid_rst_perr", 32'(u_if.parity_err), 32'd0);
    check("mid_rst_ovr", 32'(u_if.overrun), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    nw = n_words;
    rst_n = 1'b1;
    u_if.rx_ready = 1'b1;
    idle(NF * CPB);
    check("rst_no_word", 32'(n_words), 32'(nw));
    send_frame(9'h099, 1'b0, 1'b0, 1'b1, k);
    idle(2 * CPB);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
